// File: rtl/bnn_ctrl_pkg.sv
// Shared types and helpers for the binarized convolution control path.
// Holds the sequencer state encoding and the scan period calculation.
package bnn_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_ADDR_W = 5;

   // One row slot must cover both the input reads and the drained pipeline writes.
   function automatic int calc_period(input int in_cols, input int pipe_lat, input int out_cols);
      return (in_cols > pipe_lat + out_cols) ? in_cols : (pipe_lat + out_cols);
   endfunction

endpackage

// File: rtl/bnn_scan_sequencer_wrap_counter.sv
// Modulo-MAX counter with synchronous clear; wrap flags the increment that
// returns it to zero so counters can be chained.
module wrap_counter #(
   parameter int MAX = 2,
   parameter int W   = $clog2(MAX) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      wrap    = inc && (count_q == LAST);
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = wrap ? '0 : (count_q + W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/bnn_scan_sequencer.sv
// Address/enable sequencer for the binarized convolution datapath: scans
// columns, rows and channels with start/done handshake and stall support.
module bnn_scan_sequencer
   import bnn_ctrl_pkg::*;
#(
   parameter int IN_COLS    = 32,
   parameter int KSIZE      = 5,
   parameter int OUT_ROWS   = 28,
   parameter int PIPE_LAT   = 6,
   parameter int CHANNELS   = 1,
   parameter int ADDR_W     = DEFAULT_ADDR_W,
   parameter int CONTINUOUS = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stall,
   output logic                        busy,
   output logic                        done,
   output logic                        in_rd_en,
   output logic [ADDR_W-1:0]           in_col,
   output logic [ADDR_W-1:0]           in_row,
   output logic                        out_wr_en,
   output logic [ADDR_W-1:0]           out_col,
   output logic [ADDR_W-1:0]           out_row,
   output logic [$clog2(CHANNELS):0]   ch_idx,
   output logic                        buffer_en
);

   localparam int OUT_COLS = IN_COLS - KSIZE + 1;
   localparam int PERIOD   = calc_period(IN_COLS, PIPE_LAT, OUT_COLS);
   localparam int CNT_W    = $clog2(PERIOD) + 1;
   localparam int ROW_W    = $clog2(OUT_ROWS) + 1;
   localparam int CH_W     = $clog2(CHANNELS) + 1;

   if (IN_COLS > 2 ** ADDR_W) begin : g_err_in_cols
      $error("IN_COLS does not fit in ADDR_W");
   end
   if (OUT_ROWS > 2 ** ADDR_W) begin : g_err_out_rows
      $error("OUT_ROWS does not fit in ADDR_W");
   end
   if (KSIZE > IN_COLS) begin : g_err_ksize
      $error("KSIZE exceeds IN_COLS");
   end

   state_e state_q;
   state_e state_d;

   logic             adv;
   logic             clr;
   logic [CNT_W-1:0] cnt;
   logic [ROW_W-1:0] row;
   logic [CH_W-1:0]  ch;
   logic             cnt_wrap;
   logic             row_wrap;
   logic             ch_wrap;

   assign adv = (state_q == RUN) && !stall;
   assign clr = (state_q == IDLE) && start;

   // Phase -> row -> channel chain; ch_wrap marks the final scan cycle of a job.
   wrap_counter #(.MAX(PERIOD), .W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (adv),
      .count (cnt),
      .wrap  (cnt_wrap)
   );

   wrap_counter #(.MAX(OUT_ROWS), .W(ROW_W)) u_row (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (cnt_wrap),
      .count (row),
      .wrap  (row_wrap)
   );

   wrap_counter #(.MAX(CHANNELS), .W(CH_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (row_wrap),
      .count (ch),
      .wrap  (ch_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (ch_wrap && (CONTINUOUS == 0)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   int cnt_i;
   int in_col_i;
   int out_col_i;
   int row_i;

   // Counters are back at zero outside RUN, so addresses need no extra gating.
   always_comb begin
      cnt_i     = int'(cnt);
      row_i     = int'(row);
      busy      = (state_q == RUN);
      done      = (state_q == DONE);
      buffer_en = adv;
      in_rd_en  = adv && (cnt_i < IN_COLS);
      out_wr_en = adv && (cnt_i >= PIPE_LAT) && (cnt_i < PIPE_LAT + OUT_COLS);
      in_col_i  = (cnt_i < IN_COLS) ? cnt_i : (IN_COLS - 1);
      out_col_i = out_wr_en ? (cnt_i - PIPE_LAT) : 0;
      in_col    = ADDR_W'(in_col_i);
      out_col   = ADDR_W'(out_col_i);
      in_row    = ADDR_W'(row_i);
      out_row   = ADDR_W'(row_i);
      ch_idx    = ch;
   end

endmodule

// File: tb/tb_bnn_scan_sequencer.sv
// Directed bench for bnn_scan_sequencer across default, multi-channel,
// continuous and reduced-size configurations.
module tb_bnn_scan_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall;
   logic st_def, st_ch3, st_cont, st_sm;

   logic       d_busy, d_done, d_rd, d_wr, d_buf;
   logic [4:0] d_icol, d_irow, d_ocol, d_orow;
   logic [0:0] d_ch;
   logic       c_busy, c_done, c_rd, c_wr, c_buf;
   logic [4:0] c_icol, c_irow, c_ocol, c_orow;
   logic [2:0] c_ch;
   logic       n_busy, n_done, n_rd, n_wr, n_buf;
   logic [4:0] n_icol, n_irow, n_ocol, n_orow;
   logic [0:0] n_ch;
   logic       s_busy, s_done, s_rd, s_wr, s_buf;
   logic [4:0] s_icol, s_irow, s_ocol, s_orow;
   logic [0:0] s_ch;

   bnn_scan_sequencer u_def (
      .clk(clk), .rst(rst), .start(st_def), .stall(stall),
      .busy(d_busy), .done(d_done), .in_rd_en(d_rd), .in_col(d_icol), .in_row(d_irow),
      .out_wr_en(d_wr), .out_col(d_ocol), .out_row(d_orow), .ch_idx(d_ch), .buffer_en(d_buf)
   );

   bnn_scan_sequencer #(.CHANNELS(3)) u_ch3 (
      .clk(clk), .rst(rst), .start(st_ch3), .stall(stall),
      .busy(c_busy), .done(c_done), .in_rd_en(c_rd), .in_col(c_icol), .in_row(c_irow),
      .out_wr_en(c_wr), .out_col(c_ocol), .out_row(c_orow), .ch_idx(c_ch), .buffer_en(c_buf)
   );

   bnn_scan_sequencer #(.CONTINUOUS(1)) u_cont (
      .clk(clk), .rst(rst), .start(st_cont), .stall(stall),
      .busy(n_busy), .done(n_done), .in_rd_en(n_rd), .in_col(n_icol), .in_row(n_irow),
      .out_wr_en(n_wr), .out_col(n_ocol), .out_row(n_orow), .ch_idx(n_ch), .buffer_en(n_buf)
   );

   bnn_scan_sequencer #(.IN_COLS(16), .KSIZE(3), .OUT_ROWS(14), .PIPE_LAT(4)) u_sm (
      .clk(clk), .rst(rst), .start(st_sm), .stall(stall),
      .busy(s_busy), .done(s_done), .in_rd_en(s_rd), .in_col(s_icol), .in_row(s_irow),
      .out_wr_en(s_wr), .out_col(s_ocol), .out_row(s_orow), .ch_idx(s_ch), .buffer_en(s_buf)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ph, rw, exp_col, rd_n, wr_n, done_n, done_cyc, idle_n;
      logic exp_rd, exp_wr;

      rst = 1'b1; stall = 1'b0;
      st_def = 1'b0; st_ch3 = 1'b0; st_cont = 1'b0; st_sm = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Reset values
      chk("rst_busy", 32'(d_busy), 32'(0));
      chk("rst_done", 32'(d_done), 32'(0));
      chk("rst_rd", 32'(d_rd), 32'(0));
      chk("rst_wr", 32'(d_wr), 32'(0));
      chk("rst_buf", 32'(d_buf), 32'(0));
      chk("rst_addr", 32'({d_icol, d_irow, d_ocol, d_orow}), 32'(0));
      chk("rst_ch", 32'(d_ch), 32'(0));
      chk("rst_busy_others", 32'({c_busy, n_busy, s_busy}), 32'(0));

      // Full default job, every RUN cycle checked against the scan model
      st_def = 1'b1; tick(); st_def = 1'b0;
      rd_n = 0; wr_n = 0; done_n = 0; done_cyc = 0;
      for (int cyc = 1; cyc <= 960; cyc++) begin
         if (cyc <= 952) begin
            ph      = (cyc - 1) % 34;
            rw      = (cyc - 1) / 34;
            exp_rd  = (ph < 32);
            exp_wr  = (ph >= 6) && (ph < 34);
            exp_col = (ph < 32) ? ph : 31;
            chk("def_busy", 32'(d_busy), 32'(1));
            chk("def_rd", 32'(d_rd), 32'(exp_rd));
            chk("def_wr", 32'(d_wr), 32'(exp_wr));
            chk("def_in_col", 32'(d_icol), 32'(exp_col));
            chk("def_out_col", 32'(d_ocol), exp_wr ? 32'(ph - 6) : 32'(0));
            chk("def_row", 32'({d_irow, d_orow}), 32'({rw[4:0], rw[4:0]}));
         end
         rd_n += int'(d_rd);
         wr_n += int'(d_wr);
         if (d_done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
      end
      chk("def_rd_total", 32'(rd_n), 32'(896));
      chk("def_wr_total", 32'(wr_n), 32'(784));
      chk("def_done_count", 32'(done_n), 32'(1));
      chk("def_done_cycle", 32'(done_cyc), 32'(953));
      chk("def_idle_busy", 32'(d_busy), 32'(0));

      // Stall for 10 cycles at cnt=15; a stray start mid-job is ignored
      st_def = 1'b1; tick(); st_def = 1'b0;
      done_n = 0; done_cyc = 0;
      for (int cyc = 1; cyc <= 980; cyc++) begin
         if (cyc == 16) stall = 1'b1;
         if (cyc == 26) stall = 1'b0;
         st_def = (cyc == 100);
         #1;
         if (cyc == 20) begin
            chk("stall_rd", 32'(d_rd), 32'(0));
            chk("stall_wr", 32'(d_wr), 32'(0));
            chk("stall_buf", 32'(d_buf), 32'(0));
            chk("stall_busy", 32'(d_busy), 32'(1));
            chk("stall_in_col", 32'(d_icol), 32'(15));
            chk("stall_out_col", 32'(d_ocol), 32'(0));
         end
         if (cyc == 26) begin
            chk("resume_rd", 32'(d_rd), 32'(1));
            chk("resume_in_col", 32'(d_icol), 32'(15));
            chk("resume_out_col", 32'(d_ocol), 32'(9));
         end
         if (cyc == 27) chk("resume_next_col", 32'(d_icol), 32'(16));
         if (d_done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
      end
      st_def = 1'b0;
      chk("stall_done_count", 32'(done_n), 32'(1));
      chk("stall_done_cycle", 32'(done_cyc), 32'(963));

      // Reset mid-job at row 12, then restart from row 0 col 0
      st_def = 1'b1; tick(); st_def = 1'b0;
      for (int cyc = 1; cyc < 420; cyc++) tick();
      chk("midrst_row_before", 32'(d_irow), 32'(12));
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_ctrl", 32'({d_busy, d_done, d_rd, d_wr, d_buf}), 32'(0));
      chk("midrst_addr", 32'({d_icol, d_irow, d_ocol, d_orow, d_ch}), 32'(0));
      done_n = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         done_n += int'(d_done) + int'(d_busy);
         tick();
      end
      chk("midrst_stays_idle", 32'(done_n), 32'(0));
      st_def = 1'b1; tick(); st_def = 1'b0;
      chk("restart_rd", 32'(d_rd), 32'(1));
      chk("restart_pos", 32'({d_icol, d_irow}), 32'(0));
      chk("restart_busy", 32'(d_busy), 32'(1));
      rst = 1'b1; tick(); rst = 1'b0;

      // Three channel passes
      st_ch3 = 1'b1; tick(); st_ch3 = 1'b0;
      done_n = 0; done_cyc = 0;
      for (int cyc = 1; cyc <= 2870; cyc++) begin
         if (cyc == 952)  chk("ch3_ch_952", 32'(c_ch), 32'(0));
         if (cyc == 953)  chk("ch3_ch_953", 32'(c_ch), 32'(1));
         if (cyc == 953)  chk("ch3_pos_953", 32'({c_icol, c_irow}), 32'(0));
         if (cyc == 1904) chk("ch3_ch_1904", 32'(c_ch), 32'(1));
         if (cyc == 1905) chk("ch3_ch_1905", 32'(c_ch), 32'(2));
         if (cyc == 2856) chk("ch3_last_row", 32'(c_irow), 32'(27));
         if (cyc == 2858) chk("ch3_idle", 32'({c_busy, c_ch}), 32'(0));
         if (c_done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
      end
      chk("ch3_done_count", 32'(done_n), 32'(1));
      chk("ch3_done_cycle", 32'(done_cyc), 32'(2857));

      // Continuous mode wraps back to row 0 and never finishes
      st_cont = 1'b1; tick(); st_cont = 1'b0;
      done_n = 0; idle_n = 0;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
         if (cyc == 952) begin
            chk("cont_last_row", 32'(n_irow), 32'(27));
            chk("cont_last_in_col", 32'(n_icol), 32'(31));
            chk("cont_last_out_col", 32'(n_ocol), 32'(27));
         end
         if (cyc == 953) begin
            chk("cont_wrap_pos", 32'({n_icol, n_irow, n_ocol, n_ch}), 32'(0));
            chk("cont_wrap_rd", 32'(n_rd), 32'(1));
         end
         done_n += int'(n_done);
         idle_n += int'(!n_busy);
         tick();
      end
      chk("cont_no_done", 32'(done_n), 32'(0));
      chk("cont_always_busy", 32'(idle_n), 32'(0));
      rst = 1'b1; tick(); rst = 1'b0;

      // Reduced geometry: PERIOD 18, 14 rows
      st_sm = 1'b1; tick(); st_sm = 1'b0;
      done_n = 0; done_cyc = 0;
      for (int cyc = 1; cyc <= 270; cyc++) begin
         if (cyc == 4) chk("sm_wr_cnt3", 32'(s_wr), 32'(0));
         if (cyc == 5) chk("sm_first_wr", 32'({s_wr, s_ocol}), 32'({1'b1, 5'd0}));
         if (cyc == 17) chk("sm_rd_cnt16", 32'({s_rd, s_icol}), 32'({1'b0, 5'd15}));
         if (cyc == 18) chk("sm_last_wr", 32'({s_wr, s_ocol}), 32'({1'b1, 5'd13}));
         if (cyc == 19) chk("sm_row1", 32'({s_irow, s_icol, s_wr}), 32'({5'd1, 5'd0, 1'b0}));
         if (s_done) begin
            done_n++;
            done_cyc = cyc;
         end
         tick();
      end
      chk("sm_done_count", 32'(done_n), 32'(1));
      chk("sm_done_cycle", 32'(done_cyc), 32'(253));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
